// File: rtl/bram_transpose_ctrl.sv
// bram_transpose_ctrl: stream-side controller using one bram_mem instance as a
// ROWSxCOLS transpose buffer. Frames enter row-major, leave column-major.
// The fixed 2-cycle BRAM read latency is hidden behind a credit-checked FIFO.
// Optional feature macro: TPOSE_STALL_CNT_EN (adds stall_cnt output).
module bram_transpose_ctrl #(
    parameter int DATAW       = 8,
    parameter int ROWS        = 8,
    parameter int COLS        = 8,
    parameter int DEPTH       = ROWS * COLS,
    parameter int ADDRW       = $clog2(DEPTH),
    parameter int OFIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] mem_wdata,
    output logic [ADDRW-1:0] mem_waddr,
    output logic             mem_wen,
    output logic [ADDRW-1:0] mem_raddr,
    input  logic [DATAW-1:0] mem_rdata,
`ifdef TPOSE_STALL_CNT_EN
    output logic [31:0]      stall_cnt,
`endif
    output logic             frame_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
    localparam int NW = $clog2(OFIFO_DEPTH + 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [RW-1:0]    wr_r_q, wr_r_d;
    logic [CW-1:0]    wr_c_q, wr_c_d;
    logic [RW-1:0]    rd_r_q, rd_r_d;
    logic [CW-1:0]    rd_c_q, rd_c_d;
    logic             rd_done_q, rd_done_d;
    logic [1:0]       vld_q, vld_d;
    logic [PW-1:0]    fifo_wp_q, fifo_wp_d;
    logic [PW-1:0]    fifo_rp_q, fifo_rp_d;
    logic [NW-1:0]    fifo_cnt_q, fifo_cnt_d;
    logic [DATAW-1:0] fifo_mem_q [OFIFO_DEPTH];

    logic             accept;
    logic             wr_last;
    logic             rd_last;
    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic             last_pop;
    logic [NW:0]      occupancy;

    // Handshake decode, address generation and credit check
    always_comb begin
        accept    = in_valid & in_ready_q;
        wr_last   = (wr_r_q == RW'(ROWS - 1)) && (wr_c_q == CW'(COLS - 1));
        rd_last   = (rd_r_q == RW'(ROWS - 1)) && (rd_c_q == CW'(COLS - 1));
        // Registered count only: a pop this cycle frees its credit next cycle.
        occupancy = (NW+1)'(fifo_cnt_q) + (NW+1)'(vld_q[0]) + (NW+1)'(vld_q[1]);
        credit_ok = occupancy < (NW+1)'(OFIFO_DEPTH);
        issue     = (state_q == DRAIN) && !rd_done_q && credit_ok;
        push      = vld_q[1];
        out_valid = (fifo_cnt_q != '0);
        pop       = out_valid & out_ready;
        last_pop  = pop && (state_q == DRAIN) && rd_done_q && (vld_q == 2'b00)
                    && (fifo_cnt_q == NW'(1));

        in_ready   = in_ready_q;
        mem_wen    = accept;
        mem_wdata  = in_data;
        mem_waddr  = ADDRW'(wr_r_q) * ADDRW'(COLS) + ADDRW'(wr_c_q);
        mem_raddr  = ADDRW'(rd_r_q) * ADDRW'(COLS) + ADDRW'(rd_c_q);
        out_data   = out_valid ? fifo_mem_q[fifo_rp_q] : '0;
        frame_done = last_pop;
    end

    // FSM next-state: FILL until the last beat is accepted, DRAIN until final pop
    always_comb begin
        state_d    = state_q;
        in_ready_d = 1'b0;
        case (state_q)
            FILL: begin
                if (accept && wr_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        // in_ready is registered so it is low in reset and rises one cycle later
        in_ready_d = (state_d == FILL);
    end

    // Write counters (column inner) and read counters (row inner)
    always_comb begin
        wr_r_d    = wr_r_q;
        wr_c_d    = wr_c_q;
        rd_r_d    = rd_r_q;
        rd_c_d    = rd_c_q;
        rd_done_d = rd_done_q;
        if (accept) begin
            if (wr_c_q == CW'(COLS - 1)) begin
                wr_c_d = '0;
                wr_r_d = (wr_r_q == RW'(ROWS - 1)) ? '0 : wr_r_q + RW'(1);
            end else begin
                wr_c_d = wr_c_q + CW'(1);
            end
        end
        if (issue) begin
            if (rd_r_q == RW'(ROWS - 1)) begin
                rd_r_d = '0;
                rd_c_d = (rd_c_q == CW'(COLS - 1)) ? '0 : rd_c_q + CW'(1);
            end else begin
                rd_r_d = rd_r_q + RW'(1);
            end
            if (rd_last) begin
                rd_done_d = 1'b1;
            end
        end
        if (last_pop) begin
            rd_done_d = 1'b0;
        end
    end

    // Read-latency tracker and FIFO pointer/count bookkeeping
    always_comb begin
        vld_d      = {vld_q[0], issue};
        fifo_wp_d  = fifo_wp_q;
        fifo_rp_d  = fifo_rp_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push) begin
            fifo_wp_d = (fifo_wp_q == PW'(OFIFO_DEPTH - 1)) ? '0 : fifo_wp_q + PW'(1);
        end
        if (pop) begin
            fifo_rp_d = (fifo_rp_q == PW'(OFIFO_DEPTH - 1)) ? '0 : fifo_rp_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + NW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - NW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // State, counters, in-flight tracker and FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            in_ready_q <= 1'b0;
            wr_r_q     <= '0;
            wr_c_q     <= '0;
            rd_r_q     <= '0;
            rd_c_q     <= '0;
            rd_done_q  <= 1'b0;
            vld_q      <= '0;
            fifo_wp_q  <= '0;
            fifo_rp_q  <= '0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            wr_r_q     <= wr_r_d;
            wr_c_q     <= wr_c_d;
            rd_r_q     <= rd_r_d;
            rd_c_q     <= rd_c_d;
            rd_done_q  <= rd_done_d;
            vld_q      <= vld_d;
            fifo_wp_q  <= fifo_wp_d;
            fifo_rp_q  <= fifo_rp_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

    // FIFO storage: validity is carried by the count, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[fifo_wp_q] <= mem_rdata;
        end
    end

`ifdef TPOSE_STALL_CNT_EN
    logic [31:0] stall_q;

    // Saturating count of drain cycles where output is offered but not taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((state_q == DRAIN) && out_valid && !out_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_bram_transpose_ctrl.sv
// tb_bram_transpose_ctrl: randomized self-checking bench for bram_transpose_ctrl
// with a behavioural 2-cycle-latency BRAM and a frame-level transpose model.
module tb_bram_transpose_ctrl;

    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int N  = R * C;
    localparam int FD = 4;
    localparam int AW = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] mem_waddr;
    logic          mem_wen;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic          frame_done;
`ifdef TPOSE_STALL_CNT_EN
    logic [31:0]   stall_cnt;
`endif

    bram_transpose_ctrl #(
        .DATAW(DW), .ROWS(R), .COLS(C), .DEPTH(N), .ADDRW(AW), .OFIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .mem_wdata(mem_wdata), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
`ifdef TPOSE_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural BRAM: synchronous write, read data valid 2 cycles after raddr
    logic [DW-1:0] bmem [N];
    logic [DW-1:0] rd1;
    always @(posedge clk) begin
        if (mem_wen) bmem[mem_waddr] <= mem_wdata;
        rd1       <= bmem[mem_raddr];
        mem_rdata <= rd1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Frame-level reference model
    logic          exp_ready;
    int            wcount;
    logic [DW-1:0] frame_buf [N];
    logic [DW-1:0] frame_src [N];
    logic [DW-1:0] expq [$];
    bit            draining;
    int            pops;
    int            model_stall;

    task automatic monitor();
        bit last;
        check_eq("in_ready", 32'(in_ready), 32'(exp_ready));
        if (in_valid && exp_ready) begin
            check_eq("mem_wen", 32'(mem_wen), 1);
            check_eq("mem_waddr", 32'(mem_waddr), wcount);
            check_eq("mem_wdata", 32'(mem_wdata), 32'(in_data));
            frame_buf[wcount] = in_data;
            wcount++;
            if (wcount == N) begin
                wcount    = 0;
                exp_ready = 1'b0;
                draining  = 1'b1;
                for (int c = 0; c < C; c++)
                    for (int r = 0; r < R; r++)
                        expq.push_back(frame_buf[r*C + c]);
            end
        end else begin
            check_eq("mem_wen_idle", 32'(mem_wen), 0);
        end
        if (expq.size() == 0) begin
            check_eq("out_valid_idle", 32'(out_valid), 0);
            check_eq("frame_done_idle", 32'(frame_done), 0);
        end else if (out_valid) begin
            check_eq("out_data", 32'(out_data), 32'(expq[0]));
            if (out_ready) begin
                last = (expq.size() == 1);
                check_eq("frame_done", 32'(frame_done), 32'(last));
                void'(expq.pop_front());
                pops++;
                if (last) begin
                    draining  = 1'b0;
                    exp_ready = 1'b1;
                end
            end else begin
                model_stall++;
                check_eq("frame_done_stall", 32'(frame_done), 0);
            end
        end else begin
            check_eq("frame_done_novalid", 32'(frame_done), 0);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] d, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        monitor();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_out_data", 32'(out_data), 0);
        check_eq("rst_mem_wen", 32'(mem_wen), 0);
        check_eq("rst_mem_waddr", 32'(mem_waddr), 0);
        check_eq("rst_mem_raddr", 32'(mem_raddr), 0);
        check_eq("rst_frame_done", 32'(frame_done), 0);
`ifdef TPOSE_STALL_CNT_EN
        check_eq("rst_stall_cnt", stall_cnt, 0);
`endif
        expq.delete();
        wcount      = 0;
        draining    = 1'b0;
        pops        = 0;
        model_stall = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 0);
        exp_ready = 1'b1;
    endtask

    // mode 0: back-to-back, 1: valid two of every three cycles, 2: random
    task automatic fill(input int mode);
        int  guard;
        logic v;
        guard = 0;
        while (!draining && guard < 400) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 3 != 2);
                default: v = 1'($urandom_range(0, 1));
            endcase
            step(v, frame_src[wcount], 1'b1);
            guard++;
        end
        check_eq("fill_complete", 32'(draining), 1);
    endtask

    // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random; input noise throughout
    task automatic drain(input int mode, output int steps);
        logic rdy;
        steps = 0;
        while (draining && steps < 400) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (steps % 4 == 0) || (steps % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            step(1'($urandom_range(0, 1)), DW'($urandom), rdy);
            steps++;
        end
        check_eq("drain_complete", 32'(draining), 0);
    endtask

    initial begin
        int steps;
        int guard;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        exp_ready   = 1'b0;
        wcount      = 0;
        draining    = 1'b0;
        pops        = 0;
        model_stall = 0;
        do_reset();

        // Ascending frame, full-rate both directions
        for (int i = 0; i < N; i++) frame_src[i] = DW'(i);
        fill(0);
        drain(0, steps);
        check_eq("drain_rate", 32'(steps <= N + 3), 1);

        // Same frame with out_ready toggling 1,0,0,1
        fill(0);
        drain(1, steps);

        // Downstream stalled from drain start: four reads, then raddr holds
        fill(0);
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b0);
        check_eq("stall_raddr", 32'(mem_raddr), 32'(1 * C + 0) / C * 0 + 1);
        check_eq("stall_out_valid", 32'(out_valid), 1);
        check_eq("stall_out_data", 32'(out_data), 32'(frame_src[0]));
        drain(0, steps);
`ifdef TPOSE_STALL_CNT_EN
        check_eq("stall_cnt", stall_cnt, 32'(model_stall));
`endif

        // Input gaps every third cycle
        fill(1);
        drain(0, steps);

        // Reset mid-drain after six pops, then a fresh frame 16..31
        fill(0);
        pops  = 0;
        guard = 0;
        while (pops < 6 && guard < 100) begin
            step(1'b0, '0, 1'b1);
            guard++;
        end
        check_eq("mid_drain_pops", pops, 6);
        do_reset();
        for (int i = 0; i < N; i++) frame_src[i] = DW'(16 + i);
        fill(0);
        drain(0, steps);

        // Random frames with random handshakes
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < N; i++) frame_src[i] = DW'($urandom);
            fill(2);
            drain(2, steps);
        end
`ifdef TPOSE_STALL_CNT_EN
        check_eq("stall_cnt_final", stall_cnt, 32'(model_stall));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
